alu_issue_queue: RTL and testbench

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

---
 rtl/alu_issue_queue.sv | 114 +++++++++++
 tb/tb_alu_issue_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Small in-order issue queue in front of a combinational ALU, with one registered
// writeback slot that holds its result under backpressure.
package alu_iq_pkg;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_EQ, OP_NE, OP_LTS, OP_LTU
  } fu_op_t;

  typedef struct packed {
    fu_op_t                   operator;
    logic [63:0]              operand_a;
    logic [63:0]              operand_b;
    logic [63:0]              imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;
endpackage

module alu_issue_queue
  import alu_iq_pkg::fu_data_t;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned TRANS_ID_BITS = alu_iq_pkg::TRANS_ID_BITS
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  fu_data_t                   fu_data_i,
  output fu_data_t                   alu_fu_data_o,
  input  logic [63:0]                alu_result_i,
  input  logic                       alu_branch_res_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [63:0]                wb_result_o,
  output logic                       wb_branch_res_o,
  output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fu_data_t                 r_mem [DEPTH];
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [CNT_W-1:0]         r_count;
  logic                     r_wb_valid;
  logic [63:0]              r_wb_result;
  logic                     r_wb_branch_res;
  logic [TRANS_ID_BITS-1:0] r_wb_trans_id;

  logic w_not_empty;
  logic w_accept;
  logic w_advance;

  assign w_not_empty   = (r_count != '0);
  assign issue_ready_o = (r_count < FULL) & ~flush_i;
  assign w_accept      = issue_valid_i & issue_ready_o;
  // The output slot refills in the same cycle it is drained, so a full pipe runs at one op per cycle.
  assign w_advance     = w_not_empty & (~r_wb_valid | wb_ready_i);
  assign alu_fu_data_o = w_not_empty ? r_mem[r_rd_ptr] : '0;

  // NOTE: storage has no reset; the count alone says which entries are live.
  always_ff @(posedge clk_i) begin
    if (w_accept) r_mem[r_wr_ptr] <= fu_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_wb_valid <= 1'b0;
    end else if (flush_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_wb_valid <= 1'b0;
    end else begin
      if (w_accept)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_advance) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_advance})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_advance)       r_wb_valid <= 1'b1;
      else if (wb_ready_i) r_wb_valid <= 1'b0;
    end
  end

  // Payload is only qualified by r_wb_valid, so flush leaves it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_result     <= '0;
      r_wb_branch_res <= 1'b0;
      r_wb_trans_id   <= '0;
    end else if (w_advance) begin
      r_wb_result     <= alu_result_i;
      r_wb_branch_res <= alu_branch_res_i;
      r_wb_trans_id   <= alu_fu_data_o.trans_id;
    end
  end

  assign wb_valid_o      = r_wb_valid;
  assign wb_result_o     = r_wb_result;
  assign wb_branch_res_o = r_wb_branch_res;
  assign wb_trans_id_o   = r_wb_trans_id;
  assign count_o         = r_count;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: directed ops push expected results, a
// monitor pops and compares every result the writeback side consumes.
module tb_alu_issue_queue;
  import alu_iq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  fu_data_t    fu_data_i;
  fu_data_t    alu_fu_data_o;
  logic [63:0] alu_result_i;
  logic        alu_branch_res_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [63:0] wb_result_o;
  logic        wb_branch_res_o;
  logic [2:0]  wb_trans_id_o;
  logic [2:0]  count_o;

  typedef struct {
    logic [63:0] res;
    logic        br;
    logic [2:0]  tid;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_issue_queue #(.DEPTH(4), .TRANS_ID_BITS(3)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .issue_valid_i    (issue_valid_i),
    .issue_ready_o    (issue_ready_o),
    .fu_data_i        (fu_data_i),
    .alu_fu_data_o    (alu_fu_data_o),
    .alu_result_i     (alu_result_i),
    .alu_branch_res_i (alu_branch_res_i),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .wb_result_o      (wb_result_o),
    .wb_branch_res_o  (wb_branch_res_o),
    .wb_trans_id_o    (wb_trans_id_o),
    .count_o          (count_o)
  );

  always #5 clk_i = ~clk_i;

  // Combinational ALU in front of the queue head.
  always_comb begin
    alu_result_i     = '0;
    alu_branch_res_i = 1'b0;
    case (alu_fu_data_o.operator)
      OP_ADD: alu_result_i = alu_fu_data_o.operand_a + alu_fu_data_o.operand_b;
      OP_SUB: alu_result_i = alu_fu_data_o.operand_a - alu_fu_data_o.operand_b;
      OP_AND: alu_result_i = alu_fu_data_o.operand_a & alu_fu_data_o.operand_b;
      OP_OR:  alu_result_i = alu_fu_data_o.operand_a | alu_fu_data_o.operand_b;
      OP_XOR: alu_result_i = alu_fu_data_o.operand_a ^ alu_fu_data_o.operand_b;
      OP_EQ: begin
        alu_branch_res_i = (alu_fu_data_o.operand_a == alu_fu_data_o.operand_b);
        alu_result_i     = {63'b0, alu_branch_res_i};
      end
      OP_NE: begin
        alu_branch_res_i = (alu_fu_data_o.operand_a != alu_fu_data_o.operand_b);
        alu_result_i     = {63'b0, alu_branch_res_i};
      end
      default: alu_result_i = '0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Presents one op; pushes the expectation only if it is accepted at the edge.
  task automatic issue(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] tid, input logic [63:0] er, input logic eb);
    int waited = 0;
    issue_valid_i = 1'b1;
    fu_data_i     = '{operator: op, operand_a: a, operand_b: b, imm: '0, trans_id: tid};
    @(negedge clk_i);
    while (!issue_ready_o && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    if (!issue_ready_o) check("issue_timeout", 64'(issue_ready_o), 64'd1);
    else exp_q.push_back('{res: er, br: eb, tid: tid});
    @(posedge clk_i);
    #1;
    issue_valid_i = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: a result is consumed when valid and ready are both high at the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && wb_valid_o && wb_ready_i) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("wb_trans_id", 64'(wb_trans_id_o), 64'(e.tid));
          check("wb_result", wb_result_o, e.res);
          check("wb_branch_res", 64'(wb_branch_res_o), 64'(e.br));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] tid;
    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    wb_ready_i    = 1'b0;
    fu_data_i     = '0;
    #2;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst_wb_result", wb_result_o, 64'd0);
    check("rst_wb_trans_id", 64'(wb_trans_id_o), 64'd0);
    #21 rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_issue_ready", 64'(issue_ready_o), 64'd1);
    check("post_rst_alu_fu_zero", 64'(alu_fu_data_o == '0), 64'd1);

    // Single op latency: accept at edge N, valid after N+1, gone after N+2.
    @(posedge clk_i); #1;
    wb_ready_i = 1'b1;
    issue(OP_ADD, 64'd5, 64'd7, 3'd2, 64'd12, 1'b0);
    @(negedge clk_i);
    check("single_valid_n", 64'(wb_valid_o), 64'd0);
    check("single_count_n", 64'(count_o), 64'd1);
    check("single_head_a", alu_fu_data_o.operand_a, 64'd5);
    @(negedge clk_i);
    check("single_valid_n1", 64'(wb_valid_o), 64'd1);
    @(negedge clk_i);
    check("single_valid_n2", 64'(wb_valid_o), 64'd0);

    // Backpressure: five ops, the first parks in the output register.
    @(posedge clk_i); #1;
    wb_ready_i = 1'b0;
    issue(OP_SUB, 64'd20, 64'd3, 3'd1, 64'd17, 1'b0);
    issue(OP_AND, 64'hF0, 64'h3C, 3'd2, 64'h30, 1'b0);
    issue(OP_OR,  64'hF0, 64'h0F, 3'd3, 64'hFF, 1'b0);
    issue(OP_XOR, 64'hFF, 64'h0F, 3'd4, 64'hF0, 1'b0);
    issue(OP_ADD, 64'd1,  64'd1,  3'd5, 64'd2,  1'b0);
    @(negedge clk_i);
    check("bp_count_full", 64'(count_o), 64'd4);
    check("bp_issue_ready", 64'(issue_ready_o), 64'd0);
    check("bp_wb_valid", 64'(wb_valid_o), 64'd1);
    repeat (2) @(negedge clk_i);
    check("bp_hold_trans_id", 64'(wb_trans_id_o), 64'd1);
    check("bp_hold_result", wb_result_o, 64'd17);
    @(posedge clk_i); #1;
    wb_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("bp_drain_no_bubble", 64'(wb_valid_o), 64'd1);
    end
    @(negedge clk_i);
    check("bp_drain_done", 64'(wb_valid_o), 64'd0);
    check("bp_drain_count", 64'(count_o), 64'd0);

    // Wrap-around: ten back-to-back ops, trans_ids 0..7,0,1, no bubbles.
    @(posedge clk_i); #1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          tid = 3'(i);
          issue(OP_ADD, 64'(i), 64'd100, tid, 64'(100 + i), 1'b0);
        end
      end
      begin
        int w = 0;
        while (!wb_valid_o && w < 20) begin
          @(negedge clk_i);
          w++;
        end
        check("wrap_first_valid", 64'(wb_valid_o), 64'd1);
        for (int j = 0; j < 9; j++) begin
          @(negedge clk_i);
          check("wrap_no_bubble", 64'(wb_valid_o), 64'd1);
        end
      end
    join
    wait_drained("wrap_drained");

    // Branch compare results.
    @(posedge clk_i); #1;
    issue(OP_EQ, 64'd9, 64'd9, 3'd3, 64'd1, 1'b1);
    issue(OP_NE, 64'd9, 64'd9, 3'd4, 64'd0, 1'b0);
    wait_drained("branch_drained");

    // Flush with a simultaneous issue: everything pending is discarded.
    @(posedge clk_i); #1;
    wb_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tid = 3'(i);
      issue(OP_ADD, 64'(i), 64'd2, tid, 64'(i + 2), 1'b0);
    end
    @(negedge clk_i);
    check("pre_flush_count", 64'(count_o), 64'd3);
    check("pre_flush_wb_valid", 64'(wb_valid_o), 64'd1);
    @(posedge clk_i); #1;
    flush_i       = 1'b1;
    issue_valid_i = 1'b1;
    fu_data_i     = '{operator: OP_ADD, operand_a: 64'd50, operand_b: 64'd50, imm: '0, trans_id: 3'd5};
    @(negedge clk_i);
    check("flush_issue_ready", 64'(issue_ready_o), 64'd0);
    @(posedge clk_i); #1;
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_wb_valid", 64'(wb_valid_o), 64'd0);
    @(posedge clk_i); #1;
    wb_ready_i = 1'b1;
    issue(OP_ADD, 64'd10, 64'd20, 3'd6, 64'd30, 1'b0);
    wait_drained("flush_after_drained");

    // Asynchronous reset mid-burst.
    @(posedge clk_i); #1;
    wb_ready_i = 1'b0;
    issue(OP_ADD, 64'd7, 64'd7, 3'd0, 64'd14, 1'b0);
    issue(OP_ADD, 64'd8, 64'd7, 3'd1, 64'd15, 1'b0);
    issue(OP_ADD, 64'd9, 64'd7, 3'd2, 64'd16, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    check("arst_count", 64'(count_o), 64'd0);
    check("arst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("arst_wb_result", wb_result_o, 64'd0);
    check("arst_wb_branch_res", 64'(wb_branch_res_o), 64'd0);
    check("arst_wb_trans_id", 64'(wb_trans_id_o), 64'd0);
    check("arst_alu_fu_zero", 64'(alu_fu_data_o == '0), 64'd1);
    exp_q.delete();
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    check("arst_rel_issue_ready", 64'(issue_ready_o), 64'd1);
    check("arst_rel_count", 64'(count_o), 64'd0);
    @(posedge clk_i); #1;
    wb_ready_i = 1'b1;
    issue(OP_SUB, 64'd10, 64'd4, 3'd7, 64'd6, 1'b0);
    wait_drained("final_drained");
    repeat (3) @(negedge clk_i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
